writeback_arb: RTL and testbench

- Writeback-side receiver for the X__W interface. Accepts completed ops from p_num_pipes execute units (ALU, multiplier, memory, ...).
- Arbitrates round-robin among the requesting units and holds the winner in a single pipeline register.
- Drives the architectural register-file write port and a commit notification carrying the seq_num back to the sequencing/ROB logic.

---
 rtl/writeback_arb_if.sv | 34 +++
 rtl/writeback_arb.sv | 86 ++++++++
 tb/tb_writeback_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arb_if.sv
// X__W producer bundle plus register-file write port and commit notification
// for the writeback arbiter.
interface writeback_arb_if #(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = 5
);
  logic [p_num_pipes-1:0]                     X_val;
  logic [p_num_pipes-1:0]                     X_rdy;
  logic [p_num_pipes-1:0][31:0]               X_pc;
  logic [p_num_pipes-1:0][p_seq_num_bits-1:0] X_seq_num;
  logic [p_num_pipes-1:0][4:0]                X_waddr;
  logic [p_num_pipes-1:0][31:0]               X_wdata;
  logic [p_num_pipes-1:0]                     X_wen;

  logic                      rf_wen;
  logic [4:0]                rf_waddr;
  logic [31:0]               rf_wdata;
  logic                      commit_val;
  logic                      commit_rdy;
  logic [31:0]               commit_pc;
  logic [p_seq_num_bits-1:0] commit_seq_num;

  // Producers/commit consumer side
  modport master (
    output X_val, X_pc, X_seq_num, X_waddr, X_wdata, X_wen, commit_rdy,
    input  X_rdy, rf_wen, rf_waddr, rf_wdata, commit_val, commit_pc, commit_seq_num
  );

  // Arbiter side
  modport slave (
    input  X_val, X_pc, X_seq_num, X_waddr, X_wdata, X_wen, commit_rdy,
    output X_rdy, rf_wen, rf_waddr, rf_wdata, commit_val, commit_pc, commit_seq_num
  );
endinterface

// File: rtl/writeback_arb.sv
// Writeback receiver: round-robin arbitration over X__W producers into a single
// W register that drives the RF write port and the commit notification.
module writeback_arb #(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic            clk,
  input  logic            rst,
  writeback_arb_if.slave  bus
);

  localparam int unsigned PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic                      w_valid;
  logic [31:0]               w_pc;
  logic [p_seq_num_bits-1:0] w_seq;
  logic [4:0]                w_waddr;
  logic [31:0]               w_wdata;
  logic                      w_wen;
  logic [PTR_W-1:0]          rr_ptr;

  logic                      fire;
  logic                      free;
  logic                      found;
  logic                      accept;
  logic [PTR_W-1:0]          cand;
  logic [PTR_W-1:0]          gnt;
  logic [PTR_W-1:0]          rr_next;
  logic [p_num_pipes-1:0]    grant;

  assign fire   = w_valid && bus.commit_rdy;
  assign free   = !w_valid || fire;
  assign accept = rst && free && found;

  // First requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    cand  = '0;
    gnt   = '0;
    grant = '0;
    for (int k = 0; k < int'(p_num_pipes); k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % int'(p_num_pipes));
      if (!found && bus.X_val[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    if (found) grant[gnt] = 1'b1;
  end

  assign rr_next = PTR_W'((int'(gnt) + 1) % int'(p_num_pipes));

  // X_rdy gated by rst so nothing handshakes while reset is asserted
  assign bus.X_rdy = (rst && free) ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_valid <= 1'b0;
      w_pc    <= '0;
      w_seq   <= '0;
      w_waddr <= '0;
      w_wdata <= '0;
      w_wen   <= 1'b0;
      rr_ptr  <= '0;
    end else if (accept) begin
      w_valid <= 1'b1;
      w_pc    <= bus.X_pc[gnt];
      w_seq   <= bus.X_seq_num[gnt];
      w_waddr <= bus.X_waddr[gnt];
      w_wdata <= bus.X_wdata[gnt];
      w_wen   <= bus.X_wen[gnt];
      rr_ptr  <= rr_next;
    end else if (fire) begin
      w_valid <= 1'b0;
    end
  end

  // x0 writes still commit but never strobe the register file
  assign bus.rf_wen         = fire && w_wen && (w_waddr != 5'd0);
  assign bus.rf_waddr       = w_waddr;
  assign bus.rf_wdata       = w_wdata;
  assign bus.commit_val     = w_valid;
  assign bus.commit_pc      = w_pc;
  assign bus.commit_seq_num = w_seq;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed bench for writeback_arb: vector table for single-op, x0 and fairness
// cases, plus hand sequences for contention, backpressure and async reset.
module tb_writeback_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  writeback_arb_if #(.p_num_pipes(2), .p_seq_num_bits(5)) bus ();

  writeback_arb #(.p_num_pipes(2), .p_seq_num_bits(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] val;
    logic [4:0] s0, wa0;
    logic       wen0;
    logic [4:0] s1, wa1;
    logic       wen1;
    logic [1:0] e_rdy;
    logic       e_cv;
    logic       e_rf;
    logic [4:0] e_seq;
    logic [4:0] e_wa;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [1:0] val, logic [4:0] s0, logic [4:0] wa0, logic wen0,
                              logic [4:0] s1, logic [4:0] wa1, logic wen1, logic [1:0] e_rdy,
                              logic e_cv, logic e_rf, logic [4:0] e_seq, logic [4:0] e_wa);
    vec_t v;
    v.val = val; v.s0 = s0; v.wa0 = wa0; v.wen0 = wen0;
    v.s1 = s1; v.wa1 = wa1; v.wen1 = wen1;
    v.e_rdy = e_rdy; v.e_cv = e_cv; v.e_rf = e_rf; v.e_seq = e_seq; v.e_wa = e_wa;
    return v;
  endfunction

  function automatic logic [31:0] pc_of(logic [4:0] s);
    return 32'h0000_01F4 + {25'd0, s, 2'b00};
  endfunction

  function automatic logic [31:0] wd_of(logic [4:0] s);
    return 32'hDEAD_BEEC + {27'd0, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pipe(input logic p, input logic [4:0] s, input logic [4:0] wa,
                            input logic wen);
    bus.X_seq_num[p] = s;
    bus.X_pc[p]      = pc_of(s);
    bus.X_waddr[p]   = wa;
    bus.X_wdata[p]   = wd_of(s);
    bus.X_wen[p]     = wen;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] s, input logic [4:0] wa);
    chk({tag, "_seq"},   32'(bus.commit_seq_num), 32'(s));
    chk({tag, "_pc"},    bus.commit_pc, pc_of(s));
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(wa));
    chk({tag, "_wdata"}, bus.rf_wdata, wd_of(s));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    logic [1:0] rdy_s;
    errors = 0;
    checks = 0;

    // single op, x0 / no-write, then fairness after idle
    vecs[0]  = mk(2'b01,  3,  5, 1,  0,  0, 0, 2'b01, 0, 0,  0,  0);
    vecs[1]  = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 1, 1,  3,  5);
    vecs[2]  = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 0, 0,  0,  0);
    vecs[3]  = mk(2'b01,  4,  0, 1,  0,  0, 0, 2'b01, 0, 0,  0,  0);
    vecs[4]  = mk(2'b01,  5,  7, 0,  0,  0, 0, 2'b01, 1, 0,  4,  0);
    vecs[5]  = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 1, 0,  5,  7);
    vecs[6]  = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 0, 0,  0,  0);
    vecs[7]  = mk(2'b10,  0,  0, 0,  9,  9, 1, 2'b10, 0, 0,  0,  0);
    vecs[8]  = mk(2'b11, 10, 10, 1, 11, 11, 1, 2'b01, 1, 1,  9,  9);
    vecs[9]  = mk(2'b10,  0,  0, 0, 11, 11, 1, 2'b10, 1, 1, 10, 10);
    vecs[10] = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 1, 1, 11, 11);
    vecs[11] = mk(2'b00,  0,  0, 0,  0,  0, 0, 2'b00, 0, 0,  0,  0);

    // Reset with requests present: nothing may be granted
    rst = 1'b0;
    bus.commit_rdy = 1'b0;
    bus.X_val = 2'b11;
    drive_pipe(1'b0, 5'd1, 5'd1, 1'b1);
    drive_pipe(1'b1, 5'd2, 5'd2, 1'b1);
    next_cycle();
    next_cycle();
    #1;
    chk("rst_rdy",    32'(bus.X_rdy), 32'd0);
    chk("rst_cval",   32'(bus.commit_val), 32'd0);
    chk("rst_rfwen",  32'(bus.rf_wen), 32'd0);
    chk("rst_pc",     bus.commit_pc, 32'd0);
    chk("rst_seq",    32'(bus.commit_seq_num), 32'd0);
    chk("rst_waddr",  32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata",  bus.rf_wdata, 32'd0);
    bus.X_val = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    bus.commit_rdy = 1'b1;

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      bus.X_val = vecs[i].val;
      drive_pipe(1'b0, vecs[i].s0, vecs[i].wa0, vecs[i].wen0);
      drive_pipe(1'b1, vecs[i].s1, vecs[i].wa1, vecs[i].wen1);
      #1;
      chk($sformatf("v%0d_rdy", i),   32'(bus.X_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_cval", i),  32'(bus.commit_val), 32'(vecs[i].e_cv));
      chk($sformatf("v%0d_rfwen", i), 32'(bus.rf_wen), 32'(vecs[i].e_rf));
      if (vecs[i].e_cv) chk_commit($sformatf("v%0d", i), vecs[i].e_seq, vecs[i].e_wa);
    end

    // Contention from reset: commits interleave 0..7 back to back
    next_cycle();
    bus.X_val = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      next_cycle();
      bus.X_val = {n1 < 4, n0 < 4};
      drive_pipe(1'b0, 5'(2 * n0),     5'(2 * n0 + 1), 1'b1);
      drive_pipe(1'b1, 5'(2 * n1 + 1), 5'(2 * n1 + 2), 1'b1);
      #1;
      rdy_s = bus.X_rdy;
      chk($sformatf("cont%0d_rdy", cyc), 32'(rdy_s),
          (cyc < 8) ? (32'd1 << (cyc % 2)) : 32'd0);
      chk($sformatf("cont%0d_cval", cyc),  32'(bus.commit_val), 32'(cyc >= 1));
      chk($sformatf("cont%0d_rfwen", cyc), 32'(bus.rf_wen), 32'(cyc >= 1));
      if (cyc >= 1) chk_commit($sformatf("cont%0d", cyc), 5'(cyc - 1), 5'(cyc));
      if (rdy_s[0]) n0++;
      if (rdy_s[1]) n1++;
    end

    // Backpressure: W holds for three stalled cycles, then fire + accept together
    next_cycle();
    bus.X_val = 2'b01;
    drive_pipe(1'b0, 5'd20, 5'd3, 1'b1);
    #1;
    chk("bp_load_rdy", 32'(bus.X_rdy), 32'b01);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus.commit_rdy = 1'b0;
      bus.X_val = 2'b10;
      drive_pipe(1'b1, 5'd21, 5'd4, 1'b1);
      #1;
      chk($sformatf("bp%0d_rdy", c),   32'(bus.X_rdy), 32'd0);
      chk($sformatf("bp%0d_cval", c),  32'(bus.commit_val), 32'd1);
      chk($sformatf("bp%0d_rfwen", c), 32'(bus.rf_wen), 32'd0);
      chk_commit($sformatf("bp%0d", c), 5'd20, 5'd3);
    end
    next_cycle();
    bus.commit_rdy = 1'b1;
    #1;
    chk("bp_rel_rdy",   32'(bus.X_rdy), 32'b10);
    chk("bp_rel_rfwen", 32'(bus.rf_wen), 32'd1);
    chk_commit("bp_rel", 5'd20, 5'd3);
    next_cycle();
    bus.X_val = 2'b00;
    #1;
    chk("bp_next_rfwen", 32'(bus.rf_wen), 32'd1);
    chk_commit("bp_next", 5'd21, 5'd4);
    next_cycle();
    #1;
    chk("bp_idle_cval", 32'(bus.commit_val), 32'd0);

    // Async reset while stalled: outputs clear without an edge, no stale commit
    next_cycle();
    bus.X_val = 2'b01;
    drive_pipe(1'b0, 5'd25, 5'd6, 1'b1);
    next_cycle();
    bus.X_val = 2'b00;
    bus.commit_rdy = 1'b0;
    #1;
    chk("ar_pre_cval", 32'(bus.commit_val), 32'd1);
    #1;
    rst = 1'b0;
    bus.X_val = 2'b11;
    #1;
    chk("ar_cval",  32'(bus.commit_val), 32'd0);
    chk("ar_rfwen", 32'(bus.rf_wen), 32'd0);
    chk("ar_rdy",   32'(bus.X_rdy), 32'd0);
    chk("ar_seq",   32'(bus.commit_seq_num), 32'd0);
    chk("ar_pc",    bus.commit_pc, 32'd0);
    chk("ar_wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);
    bus.X_val = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    bus.commit_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      chk($sformatf("ar_post%0d_cval", c),  32'(bus.commit_val), 32'd0);
      chk($sformatf("ar_post%0d_rfwen", c), 32'(bus.rf_wen), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
